// File: rtl/sw_debounce_pkg.sv
// Shared defaults for the slide-switch conditioner.
// SW_DB_CYCLES_SIM is a short debounce window used for simulation builds.
package sw_debounce_pkg;

    localparam int unsigned SW_N_DEFAULT         = 10;
    localparam int unsigned SW_CNT_W_DEFAULT     = 16;
    localparam int unsigned SW_DB_CYCLES_DEFAULT = 50000;
    localparam int unsigned SW_DB_CYCLES_SIM     = 4;

endpackage

// File: rtl/sw_debounce_db_bit.sv
// One switch line: two-flop synchroniser, stability counter, and stable level.
// The rise output pulses for the cycle right after the level goes 0 -> 1.
module db_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned CNT_W     = SW_CNT_W_DEFAULT,
    parameter int unsigned DB_CYCLES = SW_DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count restarts whenever s2 agrees with the accepted level, so it never wraps.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        stable_d = stable_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= stable_d & ~stable_q;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch bus for the data memory switch word at 32'hC000_0000.
// Sticky rising-edge flags and irq exist only with SW_DEBOUNCE_EDGE_CAPTURE_EN defined.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned N_SW      = SW_N_DEFAULT,
    parameter int unsigned CNT_W     = SW_CNT_W_DEFAULT,
    parameter int unsigned DB_CYCLES = SW_DB_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_SW-1:0] sw_raw,
    input  logic            clr_we,
    input  logic [N_SW-1:0] clr_mask,
    output logic [N_SW-1:0] switches,
    output logic [N_SW-1:0] rise_flags,
    output logic            irq
);

    logic [N_SW-1:0] rise_vec;

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        db_bit #(
            .CNT_W     (CNT_W),
            .DB_CYCLES (DB_CYCLES)
        ) u_db_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (sw_raw[i]),
            .level   (switches[i]),
            .rise    (rise_vec[i])
        );
    end

`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
    logic [N_SW-1:0] flags_q, flags_d;

    // Set is applied after clear so a coincident set wins.
    always_comb begin
        flags_d = flags_q;
        if (clr_we) begin
            flags_d = flags_d & ~clr_mask;
        end
        flags_d = flags_d | rise_vec;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign rise_flags = flags_q;
    assign irq        = |flags_q;
`else
    logic unused_edge;
    assign unused_edge = ^{clr_we, clr_mask, rise_vec};

    assign rise_flags = '0;
    assign irq        = 1'b0;
`endif

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Conditions the ten board slide switches before they reach the data memory's switch read port, the word at 32'hC000_0000. Each raw switch line is synchronised into the clock domain, debounced with a per-bit stability counter, and presented as a clean registered 10-bit bus. An optional sticky rising-edge capture register lets software detect switch flips between polls.

## Interface
Parameters:
- N_SW, 10: number of switch lines.
- CNT_W, 16: debounce counter width.
- DB_CYCLES, 50000: consecutive cycles a new level must persist before it is accepted (1 ms at 50 MHz). Legal range 1 ≤ DB_CYCLES ≤ 2^CNT_W − 1.

Ports:
- clk  in  1  system clock, shared with the processor and data memory.
- reset_n  in  1  one clock; reset is synchronous and active-low.
- sw_raw  in  N_SW  asynchronous switch pins.
- clr_we  in  1  clear strobe for the edge flags.
- clr_mask  in  N_SW  flags to clear when clr_we=1.
- switches  out  N_SW  debounced level, drives the data memory switch input.
- rise_flags  out  N_SW  sticky rising-edge flags.
- irq  out  1  OR-reduction of rise_flags.

## Operation
- Synchroniser: two flops per bit (s1, s2), both reset to 0.
- Per-bit counter cnt, reset 0:
  - s2 == stable: cnt ← 0.
  - s2 != stable and cnt == DB_CYCLES−1: stable ← s2, cnt ← 0.
  - Otherwise: cnt ← cnt+1.
- The counter never wraps, because it restarts before reaching DB_CYCLES. Any glitch that makes s2 equal stable again restarts the count.
- switches = stable (registered, no combinational path from sw_raw). Reset value 0.
- Rising edge of bit i: stable[i] goes 0→1 in a cycle. That sets rise_flags[i] on the next edge.
- Falling edges never set flags.
- Clear: when clr_we=1, rise_flags ← rise_flags & ~clr_mask.
- Set and clear of the same bit in the same cycle: set wins, so the flag stays 1.
- irq = |rise_flags, combinational from the flag register. Reset value 0.
- Reset mid-operation clears s1, s2, cnt, stable and flags in that cycle. A switch held at 1 through reset therefore re-qualifies after release and produces a rising flag.

## Timing
- Latency from a sw_raw change that satisfies setup before edge k:
  - s2 reflects it after edge k+1.
  - switches updates at edge k+1+DB_CYCLES, provided the level is held.
- Pulses shorter than DB_CYCLES synchronised cycles are suppressed entirely.
- rise_flags[i] asserts one cycle after switches[i] rises. irq asserts in the same cycle as that flag.
- Clear takes effect at the edge where clr_we is sampled. The flag reads 0 in the following cycle.
- With DB_CYCLES=1, stable follows s2 with one cycle of delay.

## Configuration
- SW_DEBOUNCE_EDGE_CAPTURE_EN defined: flag register, clear logic and irq are built as described above.
- Not defined:
  - rise_flags tied to 0 and irq tied to 0.
  - clr_we and clr_mask are ignored.
  - Debounce behaviour and port list are unchanged.

## Structure
- Package sw_debounce_pkg holds:
  - localparams SW_N_DEFAULT=10, SW_CNT_W_DEFAULT=16, SW_DB_CYCLES_DEFAULT=50000.
  - sim constant SW_DB_CYCLES_SIM=4.
- Sub-module db_bit: one synchroniser plus counter plus stable flop, with ports clk, reset_n, raw, level, rise.
  - Instantiated N_SW times in a generate loop.
  - Edge capture stays in the top level.

## Test plan
All scenarios use DB_CYCLES=4 and CNT_W=3.
1. Hold reset_n=0 with sw_raw=10'h3FF for 3 cycles → switches=0, rise_flags=0, irq=0 throughout.
2. sw_raw 0→10'h001 held → switches=10'h001 exactly 5 edges after first sampling. rise_flags=10'h001 one cycle later, and irq=1.
3. sw_raw[3] high for 3 cycles, then low; repeat the glitch twice → switches[3] stays 0 and rise_flags[3] stays 0.
4. With rise_flags=10'h005, pulse clr_we=1 with clr_mask=10'h004 → rise_flags=10'h001 next cycle and irq stays 1. Then clear with mask 10'h3FF → irq=0.
5. Issue a clear of bit 1 in the same cycle that switches[1] rises → rise_flags[1]=1 afterwards.
6. Switches stable at 10'h2AA, then pulse reset_n=0 for 1 cycle → switches=0, then 10'h2AA again 5 cycles after release, with rise_flags=10'h2AA. With SW_DEBOUNCE_EDGE_CAPTURE_EN undefined, rise_flags and irq stay 0.
